pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080: PC loaded on a misaligned control-transfer target.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port run, input, 1: enable sequencing; 0 parks the block in IDLE.
REQ-006 Port imem_req, output, 1: instruction fetch request to instruction memory.
REQ-007 Port imem_addr, output, 32: fetch address; equals pc.
REQ-008 Port imem_rdy, input, 1: memory returns imem_rdata this cycle.
REQ-009 Port imem_rdata, input, 32: fetched instruction word.
REQ-010 Port instr, output, 32: latched instruction for the datapath.
REQ-011 Port instr_valid, output, 1: one-cycle pulse when instr is newly latched.
REQ-012 Port stall, input, 1: datapath hold request; blocks PC update.
REQ-013 Port jump, input, 1 / jump_target, input, 32: unconditional transfer.
REQ-014 Port branch_taken, input, 1 / branch_target, input, 32: taken conditional branch.
REQ-015 Port pc, output, 32 / pc_plus4, output, 32: current PC and pc+4 (for link / branch adders).
REQ-016 Port misalign_exc, output, 1: one-cycle pulse when a misaligned target is redirected.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC.
REQ-018 IDLE: imem_req=0; goes to FETCH on the next edge when run=1.
REQ-019 FETCH: imem_req=1, imem_addr=pc, held stable until imem_rdy=1; the request SHALL NOT be dropped mid-fetch.
REQ-020 FETCH with imem_rdy=1: instr<=imem_rdata, instr_valid=1 next cycle, state<=EXEC; fetch latency is 1 cycle minimum after FETCH entry.
REQ-021 EXEC with stall=1: pc, instr and state hold; instr_valid=0.
REQ-022 EXEC with stall=0: pc updates per next-PC priority jump > branch_taken > pc_plus4; state<=FETCH if run=1, else IDLE.
REQ-023 Target with bits [1:0]!=0: pc<=EXC_VECTOR and misalign_exc=1 for one cycle; pc+4 is always aligned.
REQ-024 pc_plus4 SHALL be pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
REQ-025 run deasserted in FETCH: the outstanding fetch completes, EXEC executes once, then IDLE.
REQ-026 jump, branch_taken and stall are sampled only in EXEC; they are ignored in IDLE and FETCH.
REQ-027 jump and branch_taken both high: jump wins, branch ignored.

Reset
REQ-028 On reset_n=0, the following SHALL take effect immediately, without waiting for clk:
- state=IDLE
- pc=RESET_VECTOR
- instr=0
- instr_valid=0
- misalign_exc=0
- imem_req=0
REQ-029 Reset asserted mid-FETCH SHALL abandon the fetch; imem_rdy seen after release in IDLE is ignored.
REQ-030 First fetch after release SHALL use address RESET_VECTOR.

Structure
REQ-031 Package pc_ctrl_pkg SHALL hold the FSM state enum, the default vector constants, and the 32-bit word typedef.
REQ-032 One combinational sub-module pc_next_sel SHALL implement the priority, alignment check and pc+4 computation; the FSM and registers stay in pc_fetch_ctrl.

Verification
REQ-033 Reset release, run=1, imem_rdy=1 each FETCH -> addresses 0x0, 0x4, 0x8; one instr_valid pulse per fetch.
REQ-034 In EXEC with pc=0x10: jump=1 to 0x40 and branch_taken=1 to 0x80 -> next imem_addr=0x40.
REQ-035 stall=1 for 3 EXEC cycles at pc=0x20 -> pc holds 0x20; then stall=0 -> 0x24.
REQ-036 branch_target=0x102 taken -> pc=0x80, misalign_exc one-cycle pulse.
REQ-037 pc=0xFFFF_FFFC with no transfer -> next pc=0x0.
REQ-038 reset_n low while FETCH waits on imem_rdy -> imem_req low same cycle; after release, fetch restarts at 0x0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ctrl_pkg
//  Description : Shared types and constants for the PC / fetch controller.
//                Holds the 32-bit word type, the FSM state encoding and the
//                default reset / exception vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

    localparam word_t c_reset_vector = 32'h0000_0000;
    localparam word_t c_exc_vector   = 32'h0000_0080;

    // Instruction words are 4-byte aligned; any set low bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl_if
//  Description : Instruction-memory request/response bundle.
//                imem_req   : fetch request (controller -> memory)
//                imem_addr  : fetch address (controller -> memory)
//                imem_rdy   : read data valid this cycle (memory -> controller)
//                imem_rdata : fetched instruction word (memory -> controller)
//                master = fetch controller side, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if;
    import pc_ctrl_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_rdy;
    word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selection.
//                Priority jump > branch_taken > pc+4. A selected transfer
//                target with non-zero low bits redirects to EXC_VECTOR and
//                raises o_misalign. pc+4 wraps modulo 2^32.
//  Ports       : i_pc, i_jump/i_jump_target, i_branch_taken/i_branch_target
//                o_pc_next, o_pc_plus4, o_misalign
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter word_t EXC_VECTOR = c_exc_vector
) (
    input  word_t i_pc,
    input  logic  i_jump,
    input  word_t i_jump_target,
    input  logic  i_branch_taken,
    input  word_t i_branch_target,
    output word_t o_pc_next,
    output word_t o_pc_plus4,
    output logic  o_misalign
);

    logic  w_transfer;
    word_t w_target;

    always_comb begin
        o_pc_plus4 = i_pc + 32'd4;
        w_transfer = i_jump | i_branch_taken;
        // Jump wins when both transfers are requested together.
        w_target   = i_jump ? i_jump_target : i_branch_target;
        // Only transfer targets are checked; sequential pc+4 stays aligned.
        o_misalign = w_transfer && is_misaligned(w_target[1:0]);

        if (o_misalign) begin
            o_pc_next = EXC_VECTOR;
        end else if (w_transfer) begin
            o_pc_next = w_target;
        end else begin
            o_pc_next = o_pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Program counter and instruction fetch controller.
//                IDLE -> FETCH -> EXEC -> FETCH/IDLE sequencing, holds the
//                PC and the latched instruction, steers jumps/branches and
//                redirects misaligned targets to EXC_VECTOR.
//  Ports       : clk, reset_n (async, active low), run
//                imem         : instruction memory bundle (master side)
//                instr, instr_valid      : latched instruction + 1-cycle pulse
//                stall, jump/jump_target, branch_taken/branch_target
//                pc, pc_plus4, misalign_exc
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter word_t RESET_VECTOR = c_reset_vector,
    parameter word_t EXC_VECTOR   = c_exc_vector
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    pc_fetch_ctrl_if.master        imem,
    output word_t                  instr,
    output logic                   instr_valid,
    input  logic                   stall,
    input  logic                   jump,
    input  word_t                  jump_target,
    input  logic                   branch_taken,
    input  word_t                  branch_target,
    output word_t                  pc,
    output word_t                  pc_plus4,
    output logic                   misalign_exc
);

    state_e state_q, state_d;
    word_t  pc_q, pc_d;
    word_t  instr_q, instr_d;
    logic   instr_valid_q, instr_valid_d;
    logic   misalign_exc_q, misalign_exc_d;

    word_t  w_pc_next;
    word_t  w_pc_plus4;
    logic   w_misalign;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_sel (
        .i_pc            (pc_q),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_pc_next       (w_pc_next),
        .o_pc_plus4      (w_pc_plus4),
        .o_misalign      (w_misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_VECTOR;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            misalign_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            misalign_exc_q <= misalign_exc_d;
        end
    end

    // Pulses default low; everything else holds unless the state acts on it.
    // run is only consulted in IDLE and at the end of EXEC, so a fetch in
    // flight always completes and executes once before parking.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = 1'b0;
        misalign_exc_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem.imem_rdy) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_d           = w_pc_next;
                    misalign_exc_d = w_misalign;
                    state_d        = run ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request is decoded from registered state so it drops as soon as
    // reset is asserted and never glitches within a fetch.
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = w_pc_plus4;
    assign misalign_exc   = misalign_exc_q;

endmodule
`default_nettype wire
